// File: rtl/pe_feeder_pkg.sv
// pe_pkg: shared PE widths, ctl bit positions and feeder state encoding.
package pe_pkg;
  localparam int PE_DATA_W    = 512;
  localparam int PSUM_W       = 32;
  localparam int PE_CTL_FIRST = 0;
  localparam int PE_CTL_LAST  = 1;
  typedef enum logic [1:0] {IDLE, RUN, GAP, FIN} feed_st_t;
endpackage

// File: rtl/pe_feeder.sv
// pe_feeder: streams neuron/weight chunks into the matrix PE, one dot product per weight row.
// Define PE_FEEDER_PERF_EN to add the perf_stall_cnt output.
module pe_feeder
  import pe_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 8,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_W-1:0]     vec_len,
  input  logic [CNT_W-1:0]     num_out,
  input  logic [ADDR_W-1:0]    neuron_base,
  input  logic [ADDR_W-1:0]    weight_base,
  input  logic                 out_rdy,
  output logic                 busy,
  output logic                 done,
  output logic                 nrn_rd_en,
  output logic [ADDR_W-1:0]    nrn_rd_addr,
  input  logic [PE_DATA_W-1:0] nrn_rd_data,
  output logic                 wgt_rd_en,
  output logic [ADDR_W-1:0]    wgt_rd_addr,
  input  logic [PE_DATA_W-1:0] wgt_rd_data,
  output logic [PE_DATA_W-1:0] pe_neuron,
  output logic [PE_DATA_W-1:0] pe_weight,
  output logic [1:0]           pe_ctl,
  output logic                 pe_vld
`ifdef PE_FEEDER_PERF_EN
  ,
  output logic [15:0]          perf_stall_cnt
`endif
);
  feed_st_t st, nxt;
  logic [LEN_W-1:0] len, c;
  logic [CNT_W-1:0] num, r;
  logic [ADDR_W-1:0] nb, rb;
  logic acc, issue, last_c, last_r;
  assign acc    = st == IDLE && start;
  assign issue  = st == RUN && (c != '0 || out_rdy);
  assign last_c = c == len - LEN_W'(1);
  assign last_r = r == num - CNT_W'(1);
  assign busy        = st != IDLE;
  assign nrn_rd_en   = issue;
  assign wgt_rd_en   = issue;
  assign nrn_rd_addr = issue ? nb + ADDR_W'(c) : '0;
  // rb tracks weight_base + r*vec_len incrementally, so no multiplier is needed
  assign wgt_rd_addr = issue ? rb + ADDR_W'(c) : '0;
  assign pe_neuron   = pe_vld ? nrn_rd_data : '0;
  assign pe_weight   = pe_vld ? wgt_rd_data : '0;
  always_comb begin
    nxt = st;
    unique case (st)
      IDLE: nxt = start ? ((vec_len == '0 || num_out == '0) ? FIN : RUN) : IDLE;
      RUN:  nxt = (issue && last_c) ? (last_r ? FIN : GAP) : RUN;
      GAP:  nxt = RUN;
      FIN:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= IDLE;
      len    <= '0;
      num    <= '0;
      nb     <= '0;
      rb     <= '0;
      c      <= '0;
      r      <= '0;
      pe_vld <= 1'b0;
      pe_ctl <= '0;
      done   <= 1'b0;
    end else begin
      st                   <= nxt;
      pe_vld               <= issue;
      pe_ctl[PE_CTL_FIRST] <= issue && c == '0;
      pe_ctl[PE_CTL_LAST]  <= issue && last_c;
      done                 <= st == FIN;
      if (acc) begin
        len <= vec_len;
        num <= num_out;
        nb  <= neuron_base;
        rb  <= weight_base;
        c   <= '0;
        r   <= '0;
      end else if (issue) begin
        c <= last_c ? '0 : c + LEN_W'(1);
        if (last_c) begin
          r  <= r + CNT_W'(1);
          rb <= rb + ADDR_W'(len);
        end
      end
    end
  end
`ifdef PE_FEEDER_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_stall_cnt <= '0;
    else if (acc) perf_stall_cnt <= '0;
    else if (st == RUN && c == '0 && !out_rdy && perf_stall_cnt != 16'hFFFF)
      perf_stall_cnt <= perf_stall_cnt + 16'd1;
  end
`endif
endmodule
